// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/execute/writeback bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int PERF_W = 32
);
  logic dec_valid;
  logic [AW-1:0] dec_rs1;
  logic dec_rs1_used;
  logic [AW-1:0] dec_rs2;
  logic dec_rs2_used;
  logic [AW-1:0] dec_rd;
  logic dec_rd_we;
  logic ex_ready;
  logic squash_valid;
  logic [AW-1:0] squash_rd;
  logic wb_valid;
  logic [AW-1:0] wb_rd;
  logic fence_req;
  logic issue_stall;
  logic issue_fire;
  logic busy;
  logic fence_ack;
  logic [PERF_W-1:0] stall_cycles;
  modport master (
    output dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used, dec_rd, dec_rd_we,
           ex_ready, squash_valid, squash_rd, wb_valid, wb_rd, fence_req,
    input  issue_stall, issue_fire, busy, fence_ack, stall_cycles
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used, dec_rd, dec_rd_we,
           ex_ready, squash_valid, squash_rd, wb_valid, wb_rd, fence_req,
    output issue_stall, issue_fire, busy, fence_ack, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write interlock with fence drain sequencer; HAZARD_BYPASS_EN lets
// a source whose last pending write is in writeback this cycle issue through the bypass.
module hazard_scoreboard #(
  parameter int REGISTER_DEPTH = 32,
  parameter int PENDING_W = 2,
  parameter int PERF_W = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);
  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam int CW = PENDING_W + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state;
  logic [PENDING_W-1:0] cnt [REGISTER_DEPTH];
  logic [PENDING_W-1:0] cnt_nx [REGISTER_DEPTH];
  logic [REGISTER_DEPTH-1:0] nz_nx;
  logic byp1, byp2, haz1, haz2, waw_full;
`ifdef HAZARD_BYPASS_EN
  assign byp1 = sb.wb_valid && sb.wb_rd == sb.dec_rs1 && cnt[sb.dec_rs1] == PENDING_W'(1);
  assign byp2 = sb.wb_valid && sb.wb_rd == sb.dec_rs2 && cnt[sb.dec_rs2] == PENDING_W'(1);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign haz1 = sb.dec_rs1_used && sb.dec_rs1 != '0 && cnt[sb.dec_rs1] != '0 && !byp1;
  assign haz2 = sb.dec_rs2_used && sb.dec_rs2 != '0 && cnt[sb.dec_rs2] != '0 && !byp2;
  assign waw_full = sb.dec_rd_we && sb.dec_rd != '0 && cnt[sb.dec_rd] == '1;
  assign sb.issue_stall = sb.dec_valid && (haz1 || haz2 || waw_full || state != IDLE || sb.fence_req);
  assign sb.issue_fire = sb.dec_valid && !sb.issue_stall && sb.ex_ready;
  assign cnt_nx[0] = '0;
  assign nz_nx[0] = 1'b0;
  // net of one increment and up to two decrements, clamped at zero
  for (genvar r = 1; r < REGISTER_DEPTH; r++) begin : g_cnt
    logic [CW-1:0] up, dn;
    assign up = {1'b0, cnt[r]} + CW'(sb.issue_fire && sb.dec_rd_we && sb.dec_rd == AW'(r));
    assign dn = CW'(sb.wb_valid && sb.wb_rd == AW'(r)) + CW'(sb.squash_valid && sb.squash_rd == AW'(r));
    assign cnt_nx[r] = up < dn ? '0 : PENDING_W'(up - dn);
    assign nz_nx[r] = cnt_nx[r] != '0;
    always_ff @(posedge clk)
      if (!rst) assert (up >= dn);
  end
  always_ff @(posedge clk)
    for (int i = 0; i < REGISTER_DEPTH; i++) cnt[i] <= rst ? '0 : cnt_nx[i];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sb.busy <= 1'b0;
      sb.fence_ack <= 1'b0;
      sb.stall_cycles <= '0;
    end else begin
      sb.busy <= |nz_nx;
      sb.stall_cycles <= sb.stall_cycles + PERF_W'(sb.dec_valid && sb.issue_stall);
      case (state)
        IDLE: if (sb.fence_req) state <= DRAIN;
        DRAIN: if (!sb.busy) begin
          state <= DONE;
          sb.fence_ack <= 1'b1;
        end
        default: begin
          state <= IDLE;
          sb.fence_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule
